// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with long-latency result buffer
//
// Purpose:
//   Shares the single RF write port between the in-order pipeline write-back
//   path (always wins) and a long-latency result source. Long-latency results
//   are queued in a DEPTH-entry FIFO and drained into free write-back slots.
//   Also provides a starvation stall request and an ID-stage RAW hazard flag.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wb_en_i/rd_i/data_i   pipeline write-back request
//   lu_valid_i/rd_i/data_i, lu_ready_o   long-latency result push handshake
//   rs1_idx_i, rs2_idx_i  ID-stage source indices
//   hazard_o              a live buffered entry targets a nonzero rs1/rs2
//   stall_req_o           upstream bubble request so the buffer can drain
//   reg_write_en_o, rd_idx_o, write_back_data_o   RF write port

module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rd_i,
  input  logic [31:0] lu_data_i,
  output logic        lu_ready_o,
  input  logic [4:0]  rs1_idx_i,
  input  logic [4:0]  rs2_idx_i,
  output logic        hazard_o,
  output logic        stall_req_o,
  output logic        reg_write_en_o,
  output logic [4:0]  rd_idx_o,
  output logic [31:0] write_back_data_o
);

  localparam int         AW         = $clog2(DEPTH);
  localparam int         PW         = AW + 1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [3:0]       starve_q, starve_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] head_idx;
  logic          empty;
  logic          full;
  logic          busy;
  logic          head_live;
  logic          push;
  logic          pop;
  logic          push_live;
  logic          hazard_raw;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign head_idx = rd_ptr_q[AW-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == head_idx);

  // A write to x0 is not a real write, so it leaves the slot free.
  assign busy      = wb_en_i && (wb_rd_i != 5'd0);
  assign head_live = !empty && live_q[head_idx];

  // A dead head is discarded immediately, whether or not the slot is busy,
  // so it never blocks a live entry behind it for longer than one cycle.
  assign pop  = !empty && (!live_q[head_idx] || !busy);
  assign push = lu_valid_i && !full;

  // The concurrent pipeline write is younger than any long-latency result,
  // so a same-cycle push to the same register is dead on arrival.
  assign push_live = (lu_rd_i != 5'd0) && !(busy && (lu_rd_i == wb_rd_i));

  always_comb begin
    hazard_raw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] &&
          (((rd_q[i] == rs1_idx_i) && (rs1_idx_i != 5'd0)) ||
           ((rd_q[i] == rs2_idx_i) && (rs2_idx_i != 5'd0)))) begin
        hazard_raw = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    live_d   = live_q;
    starve_d = 4'd0;

    // WAW kill of every buffered entry overwritten by the pipeline this cycle.
    for (int i = 0; i < DEPTH; i++) begin
      if (busy && (rd_q[i] == wb_rd_i)) begin
        live_d[i] = 1'b0;
      end
    end

    // Popped slots lose their live bit so the hazard scan only sees stored entries.
    if (pop) begin
      live_d[head_idx] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end

    // The push slot is never occupied when not full, so it cannot collide with the pop slot.
    if (push) begin
      live_d[wr_idx] = push_live;
      wr_ptr_d       = wr_ptr_q + PW'(1);
    end

    if (head_live && busy) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      live_q   <= '0;
      starve_q <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      live_q   <= live_d;
      starve_q <= starve_d;
    end
  end

  // Payload storage needs no reset: the live bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_idx]   <= lu_rd_i;
      data_q[wr_idx] <= lu_data_i;
    end
  end

  always_comb begin
    reg_write_en_o    = 1'b0;
    rd_idx_o          = 5'd0;
    write_back_data_o = 32'd0;
    if (!reset) begin
      if (busy) begin
        reg_write_en_o    = 1'b1;
        rd_idx_o          = wb_rd_i;
        write_back_data_o = wb_data_i;
      end else if (head_live) begin
        reg_write_en_o    = 1'b1;
        rd_idx_o          = rd_q[head_idx];
        write_back_data_o = data_q[head_idx];
      end
    end
  end

  assign lu_ready_o  = !reset && !full;
  assign hazard_o    = !reset && hazard_raw;
  assign stall_req_o = !reset && (starve_q == STARVE_LIM);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter

module tb_rf_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        lu_valid_i;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic [4:0]  rs1_idx_i;
  logic [4:0]  rs2_idx_i;
  logic        hazard_o;
  logic        stall_req_o;
  logic        reg_write_en_o;
  logic [4:0]  rd_idx_o;
  logic [31:0] write_back_data_o;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk               (clk),
    .reset             (reset),
    .wb_en_i           (wb_en_i),
    .wb_rd_i           (wb_rd_i),
    .wb_data_i         (wb_data_i),
    .lu_valid_i        (lu_valid_i),
    .lu_rd_i           (lu_rd_i),
    .lu_data_i         (lu_data_i),
    .lu_ready_o        (lu_ready_o),
    .rs1_idx_i         (rs1_idx_i),
    .rs2_idx_i         (rs2_idx_i),
    .hazard_o          (hazard_o),
    .stall_req_o       (stall_req_o),
    .reg_write_en_o    (reg_write_en_o),
    .rd_idx_o          (rd_idx_o),
    .write_back_data_o (write_back_data_o)
  );

  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   starve_m = 0;
  int   checks   = 0;
  int   errors   = 0;

  logic        o_we;
  logic [4:0]  o_rd;
  logic [31:0] o_data;
  logic        o_ready;
  logic        o_haz;
  logic        o_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [4:0] rd, input logic [31:0] d,
                       input logic v, input logic [4:0] lrd, input logic [31:0] ld);
    wb_en_i    = en;
    wb_rd_i    = rd;
    wb_data_i  = d;
    lu_valid_i = v;
    lu_rd_i    = lrd;
    lu_data_i  = ld;
  endtask

  // One clock cycle: compare DUT against the queue model, advance the model,
  // then return at the next falling edge ready for new inputs.
  task automatic cyc(input string tag);
    logic        busy, hl, e_we, e_ready, e_haz, e_stall;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    ent_t        ne;
    #1;
    o_we    = reg_write_en_o;
    o_rd    = rd_idx_o;
    o_data  = write_back_data_o;
    o_ready = lu_ready_o;
    o_haz   = hazard_o;
    o_stall = stall_req_o;

    busy    = wb_en_i && (wb_rd_i != 5'd0);
    hl      = (mq.size() > 0) && mq[0].live;
    e_we    = 1'b0;
    e_rd    = 5'd0;
    e_data  = 32'd0;
    e_ready = 1'b0;
    e_haz   = 1'b0;
    e_stall = 1'b0;
    if (!reset) begin
      e_ready = (mq.size() < DEPTH);
      e_stall = (starve_m == STARVE_MAX);
      foreach (mq[i]) begin
        if (mq[i].live && ((mq[i].rd == rs1_idx_i && rs1_idx_i != 5'd0) ||
                           (mq[i].rd == rs2_idx_i && rs2_idx_i != 5'd0)))
          e_haz = 1'b1;
      end
      if (busy) begin
        e_we = 1'b1; e_rd = wb_rd_i; e_data = wb_data_i;
      end else if (hl) begin
        e_we = 1'b1; e_rd = mq[0].rd; e_data = mq[0].data;
      end
    end

    check({tag, ".we"},    32'(o_we),    32'(e_we));
    check({tag, ".rd"},    32'(o_rd),    32'(e_rd));
    check({tag, ".data"},  o_data,       e_data);
    check({tag, ".ready"}, 32'(o_ready), 32'(e_ready));
    check({tag, ".haz"},   32'(o_haz),   32'(e_haz));
    check({tag, ".stall"}, 32'(o_stall), 32'(e_stall));

    if (reset) begin
      mq.delete();
      starve_m = 0;
    end else begin
      if (hl && busy) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : starve_m;
      else            starve_m = 0;
      if ((mq.size() > 0) && (!mq[0].live || !busy)) void'(mq.pop_front());
      if (busy) begin
        foreach (mq[i]) if (mq[i].rd == wb_rd_i) mq[i].live = 1'b0;
      end
      if (lu_valid_i && e_ready) begin
        ne.live = (lu_rd_i != 5'd0) && !(busy && lu_rd_i == wb_rd_i);
        ne.rd   = lu_rd_i;
        ne.data = lu_data_i;
        mq.push_back(ne);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rs1_idx_i = 5'd0;
    rs2_idx_i = 5'd0;
    @(negedge clk);

    // Reset state
    cyc("rst0");
    check("rst_ready", 32'(o_ready), 32'd0);
    cyc("rst1");
    reset = 1'b0;

    // Idle drain
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    cyc("drain1");
    check("drain1_ready", 32'(o_ready), 32'd1);
    check("drain1_we", 32'(o_we), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rs1_idx_i = 5'd5;
    cyc("drain2");
    check("drain2_we", 32'(o_we), 32'd1);
    check("drain2_rd", 32'(o_rd), 32'd5);
    check("drain2_data", o_data, 32'hDEADBEEF);
    check("drain2_haz", 32'(o_haz), 32'd1);
    cyc("drain3");
    check("drain3_we", 32'(o_we), 32'd0);
    check("drain3_ready", 32'(o_ready), 32'd1);
    check("drain3_haz", 32'(o_haz), 32'd0);
    rs1_idx_i = 5'd0;

    // Priority and starvation
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    cyc("starve_push");
    check("starve_push_rd", 32'(o_rd), 32'd3);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc("starve_deny");
      check("starve_deny_rd", 32'(o_rd), 32'd3);
      check("starve_deny_stall", 32'(o_stall), 32'd0);
    end
    cyc("starve_hold");
    check("starve_hold_stall", 32'(o_stall), 32'd1);
    check("starve_hold_rd", 32'(o_rd), 32'd3);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc("starve_grant");
    check("starve_grant_we", 32'(o_we), 32'd1);
    check("starve_grant_rd", 32'(o_rd), 32'd7);
    check("starve_grant_data", o_data, 32'h77);
    check("starve_grant_stall", 32'(o_stall), 32'd1);
    cyc("starve_after");
    check("starve_after_stall", 32'(o_stall), 32'd0);
    check("starve_after_we", 32'(o_we), 32'd0);

    // Full / backpressure, then pointer wrap
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd1, 32'h11);
    cyc("full_p1");
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'h22);
    cyc("full_p2");
    check("full_p2_ready", 32'(o_ready), 32'd1);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd6, 32'h66);
    cyc("full_p3");
    check("full_p3_ready", 32'(o_ready), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc("full_d1");
    check("full_d1_rd", 32'(o_rd), 32'd1);
    check("full_d1_data", o_data, 32'h11);
    cyc("full_d2");
    check("full_d2_rd", 32'(o_rd), 32'd2);
    check("full_d2_data", o_data, 32'h22);
    cyc("full_d3");
    check("full_d3_we", 32'(o_we), 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'(100 + i));
      cyc("wrap");
      if (i > 0) check("wrap_rd", 32'(o_rd), 32'(10 + i - 1));
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc("wrap_last");
    check("wrap_last_rd", 32'(o_rd), 32'd15);

    // WAW kill
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    cyc("waw_push");
    drive(1'b1, 5'd9, 32'hA, 1'b0, 5'd0, 32'd0);
    rs1_idx_i = 5'd9;
    cyc("waw_kill");
    check("waw_kill_rd", 32'(o_rd), 32'd9);
    check("waw_kill_data", o_data, 32'hA);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc("waw_drop");
    check("waw_drop_we", 32'(o_we), 32'd0);
    check("waw_drop_haz", 32'(o_haz), 32'd0);
    rs1_idx_i = 5'd0;
    cyc("waw_idle");
    check("waw_idle_ready", 32'(o_ready), 32'd1);

    // Hazard and x0
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
    cyc("haz_push");
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd0, 32'h55);
    rs1_idx_i = 5'd4;
    rs2_idx_i = 5'd0;
    cyc("haz_rs1");
    check("haz_rs1", 32'(o_haz), 32'd1);
    check("haz_x0_ready", 32'(o_ready), 32'd1);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    rs1_idx_i = 5'd0;
    rs2_idx_i = 5'd4;
    cyc("haz_rs2");
    check("haz_rs2", 32'(o_haz), 32'd1);
    check("haz_full", 32'(o_ready), 32'd0);
    rs2_idx_i = 5'd0;
    cyc("haz_rs0");
    check("haz_rs0", 32'(o_haz), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc("haz_d1");
    check("haz_d1_rd", 32'(o_rd), 32'd4);
    cyc("haz_d2");
    check("haz_d2_we", 32'(o_we), 32'd0);
    cyc("haz_d3");
    check("haz_d3_we", 32'(o_we), 32'd0);

    // Reset mid-operation
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC);
    cyc("mrst_p1");
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd13, 32'hD);
    cyc("mrst_p2");
    reset = 1'b1;
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    rs1_idx_i = 5'd12;
    cyc("mrst_in");
    check("mrst_we", 32'(o_we), 32'd0);
    check("mrst_rd", 32'(o_rd), 32'd0);
    check("mrst_data", o_data, 32'd0);
    check("mrst_ready", 32'(o_ready), 32'd0);
    check("mrst_haz", 32'(o_haz), 32'd0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rs1_idx_i = 5'd0;
    cyc("mrst_rel");
    check("mrst_rel_ready", 32'(o_ready), 32'd1);
    check("mrst_rel_we", 32'(o_we), 32'd0);
    cyc("mrst_rel2");
    check("mrst_rel2_we", 32'(o_we), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 63) == 0);
      wb_en_i    = ($urandom_range(0, 3) != 0);
      wb_rd_i    = 5'($urandom_range(0, 7));
      wb_data_i  = $urandom;
      lu_valid_i = ($urandom_range(0, 1) != 0);
      lu_rd_i    = 5'($urandom_range(0, 7));
      lu_data_i  = $urandom;
      rs1_idx_i  = 5'($urandom_range(0, 7));
      rs2_idx_i  = 5'($urandom_range(0, 7));
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
